// File: rtl/uart_receive.sv
// -----------------------------------------------------------------------------
// uart_receive
// 8N1 UART receiver for the uart_rxd (computer -> FPGA) line. It is the
// receive-side peer of uart_transmit. It synchronises the asynchronous line,
// detects the start bit, samples each bit at its midpoint and presents a byte.
//
// Configuration macro:
//   UART_RX_PARITY_EN  when defined, the frame is 8E1. An even-parity bit sits
//                      between data bit 7 and the stop bit, and
//                      parity_error_out is driven. When undefined, the frame
//                      is 8N1 and parity_error_out is tied low.
//
// Ports:
//   clk_in             system clock
//   rst_in             synchronous reset, active high
//   rx_wire_in         raw asynchronous serial line, idle high
//   data_byte_out[7:0] last good byte; held until the next good byte
//   new_data_out       one-cycle strobe: data_byte_out has just been updated
//   framing_error_out  one-cycle strobe: stop bit was sampled low
//   parity_error_out   one-cycle strobe: even-parity mismatch
//   busy_out           high whenever the receiver is inside a frame
//   state_dbg[2:0]     current FSM state encoding, for observation only
//
// Handshake: the three strobes are valid-only with no ready. A consumer must
// capture data_byte_out in the cycle new_data_out is high. The strobes are
// registered and mutually exclusive, and none is high for two consecutive
// cycles.
// -----------------------------------------------------------------------------
module uart_receive #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 460800
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_wire_in,
  output logic [7:0] data_byte_out,
  output logic       new_data_out,
  output logic       framing_error_out,
  output logic       parity_error_out,
  output logic       busy_out,
  output logic [2:0] state_dbg
);

  localparam int BAUD_BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W           = $clog2(BAUD_BIT_PERIOD);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_BIT_PERIOD - 1);
  // Start bit is checked at its midpoint, so data samples land mid-bit too.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_BIT_PERIOD / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  logic [CNT_W-1:0] cycle_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
`ifdef UART_RX_PARITY_EN
  logic             parity_bit;
`endif

  assign state_dbg = state;

`ifndef UART_RX_PARITY_EN
  assign parity_error_out = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // Synchroniser resets to the idle level, so the line must be seen
      // falling after reset before a frame can start.
      rx_s1             <= 1'b1;
      rx_s2             <= 1'b1;
      rx_prev           <= 1'b1;
      state             <= S_IDLE;
      cycle_cnt         <= '0;
      bit_cnt           <= '0;
      shift_reg         <= '0;
      data_byte_out     <= '0;
      new_data_out      <= 1'b0;
      framing_error_out <= 1'b0;
      busy_out          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit        <= 1'b0;
      parity_error_out  <= 1'b0;
`endif
    end else begin
      rx_s1   <= rx_wire_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;

      new_data_out      <= 1'b0;
      framing_error_out <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_out  <= 1'b0;
`endif
      // Lags the state by one cycle: high from the cycle after START entry
      // through the cycle IDLE is re-entered.
      busy_out <= (state != S_IDLE);

      case (state)
        S_IDLE: begin
          // Edge-triggered, so a line stuck low never retriggers.
          if (rx_prev && !rx_s2) begin
            state     <= S_START;
            cycle_cnt <= '0;
          end
        end

        S_START: begin
          if (cycle_cnt == HALF_LAST) begin
            cycle_cnt <= '0;
            if (!rx_s2) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end else begin
              state <= S_IDLE;  // glitch: drop silently
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cycle_cnt == BIT_LAST) begin
            cycle_cnt          <= '0;
            shift_reg[bit_cnt] <= rx_s2;  // LSB first
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cycle_cnt == BIT_LAST) begin
            cycle_cnt  <= '0;
            parity_bit <= rx_s2;
            state      <= S_STOP;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (cycle_cnt == BIT_LAST) begin
            cycle_cnt <= '0;
            // Leaving at the stop midpoint lets a back-to-back start edge
            // be caught with no idle gap.
            state     <= S_IDLE;
            if (!rx_s2) begin
              framing_error_out <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if ((^shift_reg) != parity_bit) begin
              parity_error_out <= 1'b1;
`endif
            end else begin
              data_byte_out <= shift_reg;
              new_data_out  <= 1'b1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          cycle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// -----------------------------------------------------------------------------
// tb_uart_receive
// Directed bench for uart_receive at default parameters (217 clocks per bit).
// It drives rx_wire_in bit by bit on falling clock edges and samples all
// outputs on falling edges. Expected bytes live in a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_uart_receive;

  localparam int BIT = 217;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // The pin falls half a cycle before edge 1. Counting edges:
  //   edges 1-2         synchroniser
  //   edge 3            edge detect
  //   108 more edges    START count 0..107
  //   8*217             data bits
  //   217*PAR           parity bit
  //   217               stop bit
  // The strobe register therefore loads on edge 2064 (+217 with parity).
  localparam int LAT       = 2 + 1 + 108 + 8 * BIT + PAR * BIT + BIT;
  localparam int FRAME_LEN = (10 + PAR) * BIT;

  // ---------------- clock / reset ----------------
  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rx_wire_in;
  logic [7:0] data_byte_out;
  logic       new_data_out;
  logic       framing_error_out;
  logic       parity_error_out;
  logic       busy_out;
  logic [2:0] state_dbg;

  always #5 clk_in = ~clk_in;

  uart_receive dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rx_wire_in        (rx_wire_in),
    .data_byte_out     (data_byte_out),
    .new_data_out      (new_data_out),
    .framing_error_out (framing_error_out),
    .parity_error_out  (parity_error_out),
    .busy_out          (busy_out),
    .state_dbg         (state_dbg)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int   cyc = 0;
  int   n_new = 0, n_fe = 0, n_pe = 0, busy_cnt = 0, last_new_cyc = 0;
  logic strobe_viol = 1'b0;
  logic prev_any = 1'b0;

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    logic any;
    if (new_data_out) begin
      n_new++;
      last_new_cyc = cyc;
      if (exp_q.size() == 0) check_val("sb_byte_expected", 32'(exp_q.size()), 1);
      else                   check_val("sb_byte", data_byte_out, exp_q.pop_front());
    end
    if (framing_error_out) n_fe++;
    if (parity_error_out)  n_pe++;
    if (busy_out)          busy_cnt++;
    if ((32'(new_data_out) + 32'(framing_error_out) + 32'(parity_error_out)) > 1)
      strobe_viol = 1'b1;
    any = new_data_out | framing_error_out | parity_error_out;
    if (any && prev_any) strobe_viol = 1'b1;
    prev_any = any;
  end

  // ---------------- driver tasks ----------------
  int frame_start_cyc = 0;

  task automatic send_bit(input logic b);
    rx_wire_in = b;
    repeat (BIT) @(negedge clk_in);
  endtask

  // Called on a falling edge; leaves the line high when done.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_b);
    frame_start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR != 0) send_bit(par_b);
    send_bit(stop_b);
    rx_wire_in = 1'b1;
  endtask

  task automatic wait_new(input string tag, input int target, input int budget);
    int n = 0;
    while (n_new < target && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (n_new < target) check_val(tag, 32'(n_new), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  int base_new, base_fe, base_pe, t0;

  initial begin
    rst_in     = 1'b1;
    rx_wire_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check_val("rst_data",  data_byte_out, 8'h00);
    check_val("rst_new",   new_data_out, 1'b0);
    check_val("rst_fe",    framing_error_out, 1'b0);
    check_val("rst_pe",    parity_error_out, 1'b0);
    check_val("rst_busy",  busy_out, 1'b0);
    check_val("rst_state", state_dbg, 3'd0);
    rst_in = 1'b0;
    repeat (5) @(negedge clk_in);

    // 1: single byte, latency
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, ^8'h55);
    wait_new("t1_timeout", 1, 500);
    check_val("t1_count",   32'(n_new), 1);
    check_val("t1_data",    data_byte_out, 8'h55);
    check_val("t1_latency", 32'(last_new_cyc - frame_start_cyc), 32'(LAT));
    repeat (20) @(negedge clk_in);
    check_val("t1_busy_low", busy_out, 1'b0);
    check_val("t1_idle",     state_dbg, 3'd0);

    // 2: 50-cycle glitch
    busy_cnt = 0;
    rx_wire_in = 1'b0;
    repeat (50) @(negedge clk_in);
    rx_wire_in = 1'b1;
    repeat (300) @(negedge clk_in);
    check_val("t2_busy_cycles", 32'(busy_cnt), 108);
    check_val("t2_no_new", 32'(n_new), 1);
    check_val("t2_no_fe",  32'(n_fe), 0);
    check_val("t2_no_pe",  32'(n_pe), 0);
    check_val("t2_data",   data_byte_out, 8'h55);

    // 3: framing error
    send_frame(8'hA3, 1'b0, ^8'hA3);
    repeat (300) @(negedge clk_in);
    check_val("t3_fe",     32'(n_fe), 1);
    check_val("t3_no_new", 32'(n_new), 1);
    check_val("t3_data",   data_byte_out, 8'h55);

    // 4: back-to-back frames
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, ^8'h00);
    t0 = last_new_cyc;
    check_val("t4_first", 32'(n_new), 2);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    wait_new("t4_timeout", 3, 500);
    check_val("t4_spacing", 32'(last_new_cyc - t0), 32'(FRAME_LEN));
    check_val("t4_data",    data_byte_out, 8'hFF);
    check_val("t4_sb_empty", 32'(exp_q.size()), 0);

    // 5: reset during data bit 4 of 0x81; the sender abandons the frame too
    base_new = n_new;
    base_fe  = n_fe;
    rx_wire_in = 1'b0;
    repeat (BIT) @(negedge clk_in);        // start
    send_bit(1'b1);                         // bit 0
    for (int i = 1; i < 4; i++) send_bit(1'b0);
    rx_wire_in = 1'b0;                      // bit 4
    repeat (100) @(negedge clk_in);
    rst_in     = 1'b1;
    rx_wire_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_val("t5_rst_data", data_byte_out, 8'h00);
    check_val("t5_rst_busy", busy_out, 1'b0);
    repeat (500) @(negedge clk_in);
    check_val("t5_no_new", 32'(n_new), 32'(base_new));
    check_val("t5_no_fe",  32'(n_fe), 32'(base_fe));
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    wait_new("t5_timeout", base_new + 1, 500);
    repeat (20) @(negedge clk_in);
    check_val("t5_count", 32'(n_new), 32'(base_new + 1));
    check_val("t5_data",  data_byte_out, 8'h3C);

`ifdef UART_RX_PARITY_EN
    // 6: parity error, then good parity
    base_new = n_new;
    base_pe  = n_pe;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (300) @(negedge clk_in);
    check_val("t6_pe",     32'(n_pe), 32'(base_pe + 1));
    check_val("t6_no_new", 32'(n_new), 32'(base_new));
    check_val("t6_data_held", data_byte_out, 8'h3C);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_new("t6_timeout", base_new + 1, 500);
    check_val("t6_data", data_byte_out, 8'h07);
    check_val("t6_pe_once", 32'(n_pe), 32'(base_pe + 1));
`else
    base_pe = 0;
    check_val("pe_never", 32'(n_pe), 32'(base_pe));
`endif

    repeat (50) @(negedge clk_in);
    check_val("strobe_rules", strobe_viol, 1'b0);
    check_val("sb_drained",   32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
